// File: rtl/tlc_pkg.sv
// Shared FSM state codes and default timing for the N-phase traffic-light controller.
package tlc_pkg;

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_ALLRED = 2'd2;
  localparam logic [1:0] ST_FLASH  = 2'd3;

  localparam int TLC_NUM_PHASES = 4;
  localparam int TLC_GREEN_MIN  = 5;
  localparam int TLC_GREEN_MAX  = 20;
  localparam int TLC_YELLOW_T   = 3;
  localparam int TLC_ALLRED_T   = 1;
  localparam int TLC_TMR_W      = 5;

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin search: first set bit of pending after phase, wrapping.
module tlc_rr_arbiter
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES = TLC_NUM_PHASES
) (
  input  logic [NUM_PHASES-1:0]         pending,
  input  logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic [$clog2(NUM_PHASES)-1:0] next_phase,
  output logic                          valid
);

  localparam int PW = $clog2(NUM_PHASES);

  logic [PW-1:0] idx_s;
  logic          hit_s;

  // Scan phase+1 .. phase+NUM_PHASES; the current phase is considered last.
  always_comb begin
    next_phase = {PW{1'b0}};
    valid      = 1'b0;
    idx_s      = {PW{1'b0}};
    hit_s      = 1'b0;
    for (int off = 1; off <= NUM_PHASES; off++) begin
      idx_s      = PW'((int'(phase) + off) % NUM_PHASES);
      hit_s      = ~valid & pending[idx_s];
      next_phase = hit_s ? idx_s : next_phase;
      valid      = valid | hit_s;
    end
  end

endmodule

// File: rtl/tlc_multi_phase.sv
// N-phase traffic-light controller: green min/max, yellow, all-red clearance, round-robin demand.
// Optional flashing mode is compiled in with `define TLC_FLASH_EN.
module tlc_multi_phase
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES = TLC_NUM_PHASES,
  parameter int GREEN_MIN  = TLC_GREEN_MIN,
  parameter int GREEN_MAX  = TLC_GREEN_MAX,
  parameter int YELLOW_T   = TLC_YELLOW_T,
  parameter int ALLRED_T   = TLC_ALLRED_T,
  parameter int TMR_W      = TLC_TMR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [NUM_PHASES-1:0]         req,
`ifdef TLC_FLASH_EN
  input  logic                          flash,
`endif
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic [NUM_PHASES-1:0]         pending
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [NUM_PHASES-1:0] ZERO = {NUM_PHASES{1'b0}};
  localparam logic [NUM_PHASES-1:0] ONE  = {{(NUM_PHASES-1){1'b0}}, 1'b1};
  localparam logic [TMR_W:0] MIN_C = (TMR_W+1)'(GREEN_MIN);
  localparam logic [TMR_W:0] MAX_C = (TMR_W+1)'(GREEN_MAX);
  localparam logic [TMR_W:0] YEL_C = (TMR_W+1)'(YELLOW_T);
  localparam logic [TMR_W:0] AR_C  = (TMR_W+1)'(ALLRED_T);

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [NUM_PHASES-1:0] pending_q, pending_d;
  logic [NUM_PHASES-1:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;

  logic [TMR_W:0]        timer_inc_s;
  logic [NUM_PHASES-1:0] cur_oh_s, next_oh_s, clr_s, other_s;
  logic [PW-1:0]         arb_next_s;
  logic                  arb_valid_s, go_s, flash_s, rest_s;

`ifdef TLC_FLASH_EN
  logic flash_on_q, flash_on_d, rest_q, rest_d;
  assign flash_s = flash;
  assign rest_s  = rest_q;
`else
  assign flash_s = 1'b0;
  assign rest_s  = 1'b0;
`endif

  tlc_rr_arbiter #(.NUM_PHASES(NUM_PHASES)) u_arb (
    .pending    (pending_q),
    .phase      (phase_q),
    .next_phase (arb_next_s),
    .valid      (arb_valid_s)
  );

  assign timer_inc_s = {1'b0, timer_q} + {{TMR_W{1'b0}}, 1'b1};
  assign cur_oh_s    = ONE << phase_q;
  assign next_oh_s   = ONE << phase_d;
  assign other_s     = pending_q & ~cur_oh_s;
  assign go_s        = (|other_s) && ((timer_inc_s >= MIN_C) || (timer_inc_s >= MAX_C));

  // State / phase sequencing; everything except leaving FLASH waits for a tick.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_GREEN: begin
        if (tick && (go_s || flash_s)) state_d = ST_YELLOW;
        else                           state_d = state_q;
      end
      ST_YELLOW: begin
        if (tick && (timer_inc_s == YEL_C)) state_d = ST_ALLRED;
        else                                state_d = state_q;
      end
      ST_ALLRED: begin
        if (tick && (timer_inc_s == AR_C)) begin
          if (flash_s) begin
            state_d = ST_FLASH;
            phase_d = {PW{1'b0}};
          end else begin
            state_d = ST_GREEN;
            phase_d = (arb_valid_s && !rest_s) ? arb_next_s : {PW{1'b0}};
          end
        end else begin
          state_d = state_q;
        end
      end
`ifdef TLC_FLASH_EN
      ST_FLASH: begin
        if (!flash_s) state_d = ST_ALLRED;
        else          state_d = state_q;
      end
`endif
      default: begin
        state_d = ST_GREEN;
        phase_d = {PW{1'b0}};
      end
    endcase
  end

  // Timer restarts on every state entry and saturates instead of wrapping.
  always_comb begin
    if (state_d != state_q)                 timer_d = {TMR_W{1'b0}};
    else if (tick && (timer_q != {TMR_W{1'b1}})) timer_d = timer_inc_s[TMR_W-1:0];
    else                                    timer_d = timer_q;
  end

  // Demand latch; both the outgoing and the incoming green phase are cleared.
  always_comb begin
    clr_s = ((state_q == ST_GREEN) ? cur_oh_s : ZERO) | ((state_d == ST_GREEN) ? next_oh_s : ZERO);
    if (state_d == ST_FLASH) pending_d = ZERO;
    else                     pending_d = (pending_q | req) & ~clr_s;
  end

`ifdef TLC_FLASH_EN
  // Flash blink phase and the "return to rest phase" marker after flashing.
  always_comb begin
    if (state_q != ST_FLASH) flash_on_d = 1'b1;
    else if (tick)           flash_on_d = ~flash_on_q;
    else                     flash_on_d = flash_on_q;
    if (state_q == ST_FLASH)      rest_d = 1'b1;
    else if (state_d == ST_GREEN) rest_d = 1'b0;
    else                          rest_d = rest_q;
  end

  // Flash-mode flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_on_q <= 1'b0;
      rest_q     <= 1'b0;
    end else begin
      flash_on_q <= flash_on_d;
      rest_q     <= rest_d;
    end
  end
`endif

  // Lamps decoded from the next state so they switch on the same edge as the state.
  always_comb begin
    green_d  = ZERO;
    yellow_d = ZERO;
    case (state_d)
      ST_GREEN:  green_d  = next_oh_s;
      ST_YELLOW: yellow_d = next_oh_s;
`ifdef TLC_FLASH_EN
      ST_FLASH:  yellow_d = flash_on_d ? ONE : ZERO;
`endif
      default:   yellow_d = ZERO;
    endcase
    red_d = ~(green_d | yellow_d);
`ifdef TLC_FLASH_EN
    red_d = ((state_d == ST_FLASH) && !flash_on_d) ? ZERO : red_d;
`endif
  end

  // Main state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_GREEN;
      phase_q   <= {PW{1'b0}};
      timer_q   <= {TMR_W{1'b0}};
      pending_q <= ZERO;
      green_q   <= ONE;
      yellow_q  <= ZERO;
      red_q     <= ~ONE;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      red_q     <= red_d;
    end
  end

  assign green   = green_q;
  assign yellow  = yellow_q;
  assign red     = red_q;
  assign phase   = phase_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_tlc_multi_phase.sv
// Self-checking bench for tlc_multi_phase (default parameters, flash feature off).
module tb_tlc_multi_phase;

  localparam int NP   = 4;
  localparam int GMIN = 5;
  localparam int YT   = 3;
  localparam int AT   = 1;
  localparam int TSAT = 31;

  logic       clk = 1'b0;
  logic       rst_n, tick;
  logic [3:0] req;
  logic [3:0] green, yellow, red, pending;
  logic [1:0] phase;

  always #5 clk = ~clk;

  tlc_multi_phase dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req),
`ifdef TLC_FLASH_EN
    .flash(1'b0),
`endif
    .green(green), .yellow(yellow), .red(red), .phase(phase), .pending(pending)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: which lamp colour owns the road, how long, and the demand set.
  typedef enum int {M_GO, M_CAUTION, M_CLEAR} mmode_t;
  mmode_t     m_mode;
  int         m_ph, m_ticks;
  logic [3:0] m_pend;

  typedef struct {
    logic       t;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] ph;
    logic [3:0] pend;
  } vec_t;
  vec_t tbl [9];

  localparam logic [17:0] RESET_VEC = {4'b0001, 4'b0000, 4'b1110, 2'd0, 4'b0000};

  function automatic int rr_pick(input logic [3:0] p, input int from);
    for (int k = 1; k <= NP; k++) begin
      if (p[(from + k) % NP]) return (from + k) % NP;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = M_GO; m_ph = 0; m_ticks = 0; m_pend = 4'b0000;
  endtask

  task automatic model_step(input logic t, input logic [3:0] r);
    logic [3:0] clr_now, clr_new;
    mmode_t nm;
    int np;
    nm = m_mode;
    np = m_ph;
    clr_now = (m_mode == M_GO) ? 4'(1 << m_ph) : 4'b0000;
    if (t) begin
      case (m_mode)
        M_GO:      if (((m_pend & ~clr_now) != 4'b0000) && (m_ticks + 1 >= GMIN)) nm = M_CAUTION;
        M_CAUTION: if (m_ticks + 1 == YT) nm = M_CLEAR;
        M_CLEAR:   if (m_ticks + 1 == AT) begin
                     nm = M_GO;
                     np = (m_pend != 4'b0000) ? rr_pick(m_pend, m_ph) : 0;
                   end
        default:   nm = M_GO;
      endcase
    end
    if (nm != m_mode) m_ticks = 0;
    else if (t)       m_ticks = (m_ticks < TSAT) ? m_ticks + 1 : TSAT;
    clr_new = (nm == M_GO) ? 4'(1 << np) : 4'b0000;
    m_pend  = (m_pend | r) & ~clr_now & ~clr_new;
    m_mode  = nm;
    m_ph    = np;
  endtask

  function automatic logic [17:0] exp_pack();
    logic [3:0] g, y;
    g = (m_mode == M_GO)      ? 4'(1 << m_ph) : 4'b0000;
    y = (m_mode == M_CAUTION) ? 4'(1 << m_ph) : 4'b0000;
    return {g, y, ~(g | y), 2'(m_ph), m_pend};
  endfunction

  function automatic logic [17:0] dut_pack();
    return {green, yellow, red, phase, pending};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got g=%b y=%b r=%b ph=%0d pend=%b, want g=%b y=%b r=%b ph=%0d pend=%b",
               name, $time, act[17:14], act[13:10], act[9:6], act[5:4], act[3:0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:4], exp[3:0]);
    end
  endtask

  // One clock: drive at negedge, model follows the edge, compare at next negedge.
  task automatic cyc(input logic t, input logic [3:0] r);
    tick = t;
    req  = r;
    @(posedge clk);
    model_step(t, r);
    @(negedge clk);
    check("model", dut_pack(), exp_pack());
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; req = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check("reset", dut_pack(), RESET_VEC);
  endtask

  task automatic wait_for(input mmode_t md, input int ph, input int limit, input string name);
    int k;
    k = 0;
    while (!(m_mode == md && (ph < 0 || m_ph == ph)) && k < limit) begin
      cyc(1'b1, 4'b0000);
      k++;
    end
    n_vec++;
    if (!(m_mode == md && (ph < 0 || m_ph == ph))) begin
      n_bad++;
      $display("FAIL timeout_%s: state not reached within %0d cycles", name, limit);
    end
  endtask

  initial begin
    rst_n = 1'b1; tick = 1'b0; req = 4'b0000;
    #2;
    tbl[0] = '{1'b1, 4'b0100, 4'b0001, 4'b0000, 2'd0, 4'b0100};
    tbl[1] = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b0100};
    tbl[2] = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b0100};
    tbl[3] = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b0100};
    tbl[4] = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0100};
    tbl[5] = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0100};
    tbl[6] = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0100};
    tbl[7] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0100};
    tbl[8] = '{1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 4'b0000};

    // req[2] pulse: min green, yellow, all-red, then phase 2.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick = tbl[i].t;
      req  = tbl[i].r;
      @(posedge clk);
      model_step(tbl[i].t, tbl[i].r);
      @(negedge clk);
      check($sformatf("tbl%0d", i), dut_pack(),
            {tbl[i].g, tbl[i].y, ~(tbl[i].g | tbl[i].y), tbl[i].ph, tbl[i].pend});
    end

    // No demand: rest on phase 0 (timer saturates silently).
    do_reset();
    repeat (100) cyc(1'b1, 4'b0000);
    check("rest100", dut_pack(), RESET_VEC);

    // Demand arriving during yellow is honoured ahead of older, later-in-order demand.
    do_reset();
    cyc(1'b1, 4'b1000);
    wait_for(M_CAUTION, 0, 20, "yel0");
    cyc(1'b1, 4'b0010);
    wait_for(M_GO, -1, 20, "grn1");
    check("yellow_req", dut_pack(), {4'b0010, 4'b0000, 4'b1101, 2'd1, 4'b1000});

    // tick low freezes yellow of phase 1.
    wait_for(M_CAUTION, 1, 20, "yel1");
    repeat (50) cyc(1'b0, 4'b0000);
    check("freeze", dut_pack(), {4'b0000, 4'b0010, 4'b1101, 2'd1, 4'b1000});

    // Async reset in the middle of phase 3 yellow.
    wait_for(M_GO, 3, 30, "grn3");
    cyc(1'b1, 4'b0001);
    wait_for(M_CAUTION, 3, 20, "yel3");
    #2 rst_n = 1'b0;
    #1 check("async_rst", dut_pack(), RESET_VEC);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check("rst_hold", dut_pack(), RESET_VEC);

    // Held demand 1110 with tick every 4th cycle.
    do_reset();
    for (int k = 0; k < 600; k++) cyc((k % 4) == 0, 4'b1110);

    // Random tick density and sparse random demand.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      logic       t;
      logic [3:0] r;
      t = (k < 2000) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      cyc(t, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
